// File: rtl/control_unit.sv
// Three-cycle (FETCH/LOAD/EXEC) instruction sequencer driving the datapath controls.
// Define CTRL_SINGLE_STEP_EN to let a `step` pulse run exactly one instruction while paused.
module control_unit #(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_data,
    input  logic            pause_req,
    input  logic            step,
    input  logic            alu_zero,
    input  logic            alu_carry,
    output logic            alu_en,
    output logic [2:0]      alu_opcode,
    output logic [7:0]      imm_value,
    output logic [3:0]      write_addr,
    output logic [3:0]      ra_addr,
    output logic [3:0]      rb_addr,
    output logic            write_en,
    output logic            cpu_paused,
    output logic            halted,
    output logic [PC_W-1:0] pc
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_LOAD   = 3'd1,
        S_EXEC   = 3'd2,
        S_PAUSED = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    localparam logic [3:0] OP_LDI  = 4'b0001;
    localparam logic [3:0] OP_JMP  = 4'b0010;
    localparam logic [3:0] OP_JZ   = 4'b0011;
    localparam logic [3:0] OP_JC   = 4'b0100;
    localparam logic [3:0] OP_HALT = 4'b0111;

    state_t      state;
    logic [15:0] ir;
    logic        z_flag;
    logic        c_flag;
    logic        step_grant;

    function automatic logic is_alu(input logic [15:0] ins);
        return ins[15];
    endfunction

    function automatic logic is_ldi(input logic [15:0] ins);
        return ins[15:12] == OP_LDI;
    endfunction

    function automatic logic is_halt(input logic [15:0] ins);
        return ins[15:12] == OP_HALT;
    endfunction

    // ALU instructions have bit 15 set, so they always fall through to the default.
    function automatic logic [PC_W-1:0] next_pc(input logic [15:0]     ins,
                                                 input logic [PC_W-1:0] cur,
                                                 input logic            zf,
                                                 input logic            cf);
        logic [PC_W-1:0] tgt;
        logic [PC_W-1:0] inc;
        tgt = PC_W'(ins[7:0]);
        inc = cur + PC_W'(1);
        case (ins[15:12])
            OP_JMP:  return tgt;
            OP_JZ:   return zf ? tgt : inc;
            OP_JC:   return cf ? tgt : inc;
            default: return inc;
        endcase
    endfunction

    // Register fields decode straight from the latched instruction.
    assign alu_opcode = ir[14:12];
    assign write_addr = ir[11:8];
    assign ra_addr    = ir[7:4];
    assign rb_addr    = ir[3:0];
    assign imm_value  = ir[7:0];
    assign imem_addr  = pc;

`ifndef CTRL_SINGLE_STEP_EN
    logic unused_step;
    assign unused_step = step;
    assign step_grant  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_FETCH;
            pc         <= '0;
            ir         <= '0;
            z_flag     <= 1'b0;
            c_flag     <= 1'b0;
            alu_en     <= 1'b0;
            write_en   <= 1'b0;
            cpu_paused <= 1'b0;
            halted     <= 1'b0;
`ifdef CTRL_SINGLE_STEP_EN
            step_grant <= 1'b0;
`endif
        end else begin
            case (state)
                S_FETCH: begin
                    if (pause_req && !step_grant) begin
                        state      <= S_PAUSED;
                        cpu_paused <= 1'b1;
                    end else begin
                        state <= S_LOAD;
                    end
                end

                // Enables are registered here so they are high for exactly the EXEC cycle.
                S_LOAD: begin
                    ir       <= imem_data;
                    write_en <= is_alu(imem_data) || is_ldi(imem_data);
                    alu_en   <= is_alu(imem_data);
                    state    <= S_EXEC;
`ifdef CTRL_SINGLE_STEP_EN
                    step_grant <= 1'b0;
`endif
                end

                S_EXEC: begin
                    write_en <= 1'b0;
                    alu_en   <= 1'b0;
                    pc       <= next_pc(ir, pc, z_flag, c_flag);
                    if (is_alu(ir)) begin
                        z_flag <= alu_zero;
                        c_flag <= alu_carry;
                    end
                    if (is_halt(ir)) begin
                        state      <= S_HALTED;
                        halted     <= 1'b1;
                        cpu_paused <= 1'b1;
                    end else begin
                        state <= S_FETCH;
                    end
                end

                S_PAUSED: begin
`ifdef CTRL_SINGLE_STEP_EN
                    if (step) begin
                        step_grant <= 1'b1;
                        state      <= S_FETCH;
                        cpu_paused <= 1'b0;
                    end else
`endif
                    if (!pause_req) begin
                        state      <= S_FETCH;
                        cpu_paused <= 1'b0;
                    end
                end

                S_HALTED: begin
                    state <= S_HALTED;
                end

                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: ROM + datapath environment, decode table, directed corner
// sequences and random programs checked against an instruction-level reference model.
module tb_control_unit;
    localparam int PC_W = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [PC_W-1:0] imem_addr;
    logic [15:0]     imem_data = 16'h0000;
    logic            pause_req = 1'b0;
    logic            step = 1'b0;
    logic            alu_zero, alu_carry;
    logic            alu_en;
    logic [2:0]      alu_opcode;
    logic [7:0]      imm_value;
    logic [3:0]      write_addr, ra_addr, rb_addr;
    logic            write_en, cpu_paused, halted;
    logic [PC_W-1:0] pc;

    int checks = 0;
    int failures = 0;

    control_unit #(.PC_W(PC_W)) dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
        .pause_req(pause_req), .step(step), .alu_zero(alu_zero), .alu_carry(alu_carry),
        .alu_en(alu_en), .alu_opcode(alu_opcode), .imm_value(imm_value),
        .write_addr(write_addr), .ra_addr(ra_addr), .rb_addr(rb_addr),
        .write_en(write_en), .cpu_paused(cpu_paused), .halted(halted), .pc(pc)
    );

    always #5 clk = ~clk;

    // Synchronous instruction ROM
    logic [15:0] rom [256];
    always @(posedge clk) imem_data <= rom[imem_addr];

    // Environment ALU: returns {carry, result}
    function automatic logic [8:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {1'b0, a} - {1'b0, b};
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a | b};
            3'd4:    return {1'b0, a ^ b};
            3'd5:    return {a[7], a[6:0], 1'b0};
            3'd6:    return {a[0], 1'b0, a[7:1]};
            default: return {1'b0, b};
        endcase
    endfunction

    // Datapath model: register file written by the DUT's control outputs
    logic [7:0] dp_regs [16];
    logic       dp_clear = 1'b0;
    logic [8:0] dp_alu;
    always_comb begin
        dp_alu    = alu_f(alu_opcode, dp_regs[ra_addr], dp_regs[rb_addr]);
        alu_zero  = (dp_alu[7:0] == 8'h00);
        alu_carry = dp_alu[8];
    end
    always @(posedge clk) begin
        if (dp_clear) begin
            for (int i = 0; i < 16; i++) dp_regs[i] <= 8'h00;
        end else if (write_en && write_addr != 4'd0) begin
            dp_regs[write_addr] <= alu_en ? dp_alu[7:0] : imm_value;
        end
    end

    // Instruction-level reference model
    logic [7:0] m_pc;
    logic       m_z, m_c, m_halt;
    logic [7:0] m_regs [16];

    task automatic iss_reset();
        m_pc = 8'h00; m_z = 1'b0; m_c = 1'b0; m_halt = 1'b0;
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    endtask

    task automatic iss_step();
        logic [15:0] ins;
        logic [8:0]  r;
        logic [7:0]  nxt;
        if (m_halt) return;
        ins = rom[m_pc];
        nxt = m_pc + 8'd1;
        if (ins[15]) begin
            r = alu_f(ins[14:12], m_regs[ins[7:4]], m_regs[ins[3:0]]);
            if (ins[11:8] != 4'd0) m_regs[ins[11:8]] = r[7:0];
            m_z = (r[7:0] == 8'h00);
            m_c = r[8];
        end else begin
            case (ins[15:12])
                4'h1: if (ins[11:8] != 4'd0) m_regs[ins[11:8]] = ins[7:0];
                4'h2: nxt = ins[7:0];
                4'h3: if (m_z) nxt = ins[7:0];
                4'h4: if (m_c) nxt = ins[7:0];
                4'h7: m_halt = 1'b1;
                default: ;
            endcase
        end
        m_pc = nxt;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; dp_clear = 1'b1; pause_req = 1'b0; step = 1'b0;
        tick(2);
        dp_clear = 1'b0; rst = 1'b0;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pc"}, pc, 0);
        chk({tag, "_imem_addr"}, imem_addr, 0);
        chk({tag, "_write_en"}, write_en, 0);
        chk({tag, "_alu_en"}, alu_en, 0);
        chk({tag, "_cpu_paused"}, cpu_paused, 0);
        chk({tag, "_halted"}, halted, 0);
        chk({tag, "_fields"}, {alu_opcode, imm_value, write_addr}, 0);
    endtask

    typedef struct {
        logic [15:0] ins;
        logic        we;
        logic        ae;
        logic [7:0]  pc_next;
        logic        halt;
    } vec_t;

    vec_t tbl [11];

    int         mism;
    int         rv;
    logic [15:0] w;
    logic [15:0] ei;
    logic        exp_we, exp_ae;

    initial begin
        tbl[0]  = '{16'h1105, 1'b1, 1'b0, 8'h01, 1'b0};
        tbl[1]  = '{16'h8112, 1'b1, 1'b1, 8'h01, 1'b0};
        tbl[2]  = '{16'hF3A5, 1'b1, 1'b1, 8'h01, 1'b0};
        tbl[3]  = '{16'h2040, 1'b0, 1'b0, 8'h40, 1'b0};
        tbl[4]  = '{16'h2FFF, 1'b0, 1'b0, 8'hFF, 1'b0};
        tbl[5]  = '{16'h3020, 1'b0, 1'b0, 8'h01, 1'b0};
        tbl[6]  = '{16'h4020, 1'b0, 1'b0, 8'h01, 1'b0};
        tbl[7]  = '{16'h7000, 1'b0, 1'b0, 8'h01, 1'b1};
        tbl[8]  = '{16'h0000, 1'b0, 1'b0, 8'h01, 1'b0};
        tbl[9]  = '{16'h5123, 1'b0, 1'b0, 8'h01, 1'b0};
        tbl[10] = '{16'h6ABC, 1'b0, 1'b0, 8'h01, 1'b0};

        clear_rom();
        dp_clear = 1'b1;
        tick(1);
        chk_all_zero("reset");

        // Single-instruction decode table
        for (int t = 0; t < 11; t++) begin
            clear_rom();
            rom[0] = tbl[t].ins;
            do_reset();
            tick(1);
            chk("tbl_load_we", write_en, 0);
            tick(1);
            chk("tbl_we", write_en, tbl[t].we);
            chk("tbl_ae", alu_en, tbl[t].ae);
            chk("tbl_fields", {alu_opcode, write_addr, ra_addr, rb_addr, imm_value},
                {tbl[t].ins[14:12], tbl[t].ins[11:8], tbl[t].ins[7:4], tbl[t].ins[3:0], tbl[t].ins[7:0]});
            chk("tbl_pc_hold", pc, 0);
            tick(1);
            chk("tbl_pc_next", pc, tbl[t].pc_next);
            chk("tbl_halted", halted, tbl[t].halt);
            chk("tbl_paused", cpu_paused, tbl[t].halt);
            chk("tbl_we_off", write_en, 0);
        end

        // LDI r1,5 then HALT
        clear_rom();
        rom[0] = 16'h1105; rom[1] = 16'h7000;
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            tick(1);
            chk("halt_seq_we", write_en, (k == 2));
        end
        tick(3);
        chk("halt_halted", halted, 1);
        chk("halt_paused", cpu_paused, 1);
        chk("halt_pc", pc, 2);
        chk("halt_r1", dp_regs[1], 5);
        tick(9);
        chk("halt_pc_stays", pc, 2);
        chk("halt_we_stays", write_en, 0);

        // Counting loop: ADD pulses every 6 cycles
        clear_rom();
        rom[0] = 16'h1100; rom[1] = 16'h1201; rom[2] = 16'h8112; rom[3] = 16'h2002;
        do_reset();
        for (int k = 1; k <= 36; k++) begin
            tick(1);
            chk("loop_alu_en", alu_en, (k >= 8 && ((k - 8) % 6) == 0));
        end
        chk("loop_r1", dp_regs[1], 5);
        chk("loop_pc", pc, 2);

        // Carry/zero from FF+1: JC taken, then JZ taken
        clear_rom();
        rom[0] = 16'h13FF; rom[1] = 16'h1401; rom[2] = 16'h8534; rom[3] = 16'h400A;
        rom[10] = 16'h3014;
        do_reset();
        tick(12);
        chk("jc_taken_pc", pc, 10);
        chk("jc_r5", dp_regs[5], 0);
        tick(3);
        chk("jz_taken_pc", pc, 20);
        rom[1] = 16'h1400;
        do_reset();
        tick(12);
        chk("jc_fall_pc", pc, 4);

        // Pause raised during EXEC of instruction 1
        clear_rom();
        do_reset();
        tick(5);
        pause_req = 1'b1;
        tick(1);
        chk("pause_pc_done", pc, 2);
        chk("pause_not_yet", cpu_paused, 0);
        tick(1);
        chk("pause_paused", cpu_paused, 1);
        chk("pause_pc", pc, 2);
        tick(5);
        chk("pause_pc_hold", pc, 2);
        chk("pause_still", cpu_paused, 1);
        pause_req = 1'b0;
        tick(1);
        chk("pause_release", cpu_paused, 0);
        tick(3);
        chk("pause_resume_pc", pc, 3);

        // Single step from pc=4
        do_reset();
        tick(10);
        pause_req = 1'b1;
        tick(5);
        chk("step_paused_pc", pc, 4);
        chk("step_paused", cpu_paused, 1);
        step = 1'b1;
        tick(1);
        step = 1'b0;
        tick(10);
`ifdef CTRL_SINGLE_STEP_EN
        chk("step_pc", pc, 5);
`else
        chk("step_pc", pc, 4);
`endif
        chk("step_repaused", cpu_paused, 1);
        pause_req = 1'b0;

        // Reset in the middle of an LDI EXEC
        clear_rom();
        rom[0] = 16'h1655;
        do_reset();
        tick(2);
        chk("rstmid_we_before", write_en, 1);
        #2 rst = 1'b1;
        #1;
        chk_all_zero("rstmid");
        tick(2);
        chk("rstmid_no_write", dp_regs[6], 0);

        // Random programs against the reference model
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < 256; i++) begin
                rv = $urandom_range(0, 19);
                w  = 16'($urandom);
                if (rv < 7)       w[15] = 1'b1;
                else if (rv < 11) w[15:12] = 4'h1;
                else if (rv < 13) w[15:12] = 4'h2;
                else if (rv < 15) w[15:12] = 4'h3;
                else if (rv < 17) w[15:12] = 4'h4;
                else if (rv == 17) w[15:12] = 4'h5;
                else if (rv == 18) w[15:12] = 4'h0;
                else w[15:12] = ($urandom_range(0, 9) == 0) ? 4'h7 : 4'h6;
                rom[i] = w;
            end
            iss_reset();
            do_reset();
            for (int n = 0; n < 80; n++) begin
                tick(2);
                ei = rom[m_pc];
                exp_we = !m_halt && (ei[15] || ei[15:12] == 4'h1);
                exp_ae = !m_halt && ei[15];
                chk("rnd_we", write_en, exp_we);
                chk("rnd_ae", alu_en, exp_ae);
                if (exp_we) chk("rnd_waddr", write_addr, ei[11:8]);
                tick(1);
                iss_step();
                chk("rnd_pc", pc, m_pc);
                chk("rnd_halted", halted, m_halt);
                mism = 0;
                for (int r = 1; r < 16; r++) if (dp_regs[r] !== m_regs[r]) mism++;
                chk("rnd_regfile_mismatches", mism, 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
